// File: rtl/pzcorebus_outstanding_limiter.sv
// pzcorebus_outstanding_limiter: caps in-flight non-posted pzcorebus commands at MAX_OUTSTANDING
// Contents: pzcorebus_pkg (config/command types), pzcorebus_if (bus interface), limiter top.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_enable           1 = block non-posted commands while FULL; 0 = pass all, keep counting
//   o_outstanding      registered in-flight non-posted count
//   o_full             registered, high while the count is at the limit
//   o_error            sticky response-underflow flag
//   slave_if           upstream request source / response sink
//   master_if          downstream port toward the switch
// Optional feature: define PZCOREBUS_OUTSTANDING_LIMITER_ERROR_EN to implement the o_error flop;
// otherwise o_error is tied low (the underflow clamp is always present).
package pzcorebus_pkg;
  typedef enum logic [1:0] {
    PZCOREBUS_MEMORY_H = 2'd0,
    PZCOREBUS_MEMORY_L = 2'd1,
    PZCOREBUS_CSR      = 2'd2
  } pzcorebus_profile;
  typedef struct packed {
    pzcorebus_profile profile;
    logic [15:0]      address_width;
    logic [15:0]      data_width;
    logic [7:0]       id_width;
  } pzcorebus_config;
  // bit 3 of the encoding marks commands that expect a response
  typedef enum logic [3:0] {
    PZCOREBUS_NULL_COMMAND       = 4'b0000,
    PZCOREBUS_WRITE              = 4'b0001,
    PZCOREBUS_MESSAGE            = 4'b0010,
    PZCOREBUS_READ               = 4'b1000,
    PZCOREBUS_WRITE_NON_POSTED   = 4'b1001,
    PZCOREBUS_MESSAGE_NON_POSTED = 4'b1010
  } pzcorebus_command_type;
  typedef enum logic [1:0] {
    PZCOREBUS_NULL_RESPONSE      = 2'd0,
    PZCOREBUS_RESPONSE           = 2'd1,
    PZCOREBUS_RESPONSE_WITH_DATA = 2'd2
  } pzcorebus_response_type;
  // CSR buses acknowledge every access, so any real command there is non-posted
  function automatic logic is_non_posted_command(pzcorebus_profile profile, pzcorebus_command_type cmd);
    return (profile == PZCOREBUS_CSR) ? (cmd != PZCOREBUS_NULL_COMMAND) : cmd[3];
  endfunction
endpackage

interface pzcorebus_if
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG = '0
);
  localparam int AW = (BUS_CONFIG.address_width == 16'd0) ? 32 : int'(BUS_CONFIG.address_width);
  localparam int DW = (BUS_CONFIG.data_width == 16'd0) ? 32 : int'(BUS_CONFIG.data_width);
  localparam int IW = (BUS_CONFIG.id_width == 8'd0) ? 4 : int'(BUS_CONFIG.id_width);
  logic                   mcmd_valid;
  logic                   scmd_accept;
  pzcorebus_command_type  mcmd;
  logic [IW-1:0]          mid;
  logic [AW-1:0]          maddr;
  logic                   mdata_valid;
  logic                   sdata_accept;
  logic [DW-1:0]          mdata;
  logic [DW/8-1:0]        mdata_byteen;
  logic                   mdata_last;
  logic                   sresp_valid;
  logic                   mresp_accept;
  pzcorebus_response_type sresp;
  logic [IW-1:0]          sid;
  logic                   serror;
  logic [DW-1:0]          sdata;
  logic [1:0]             sresp_last;
  modport master (
    output mcmd_valid, mcmd, mid, maddr, mdata_valid, mdata, mdata_byteen, mdata_last, mresp_accept,
    input  scmd_accept, sdata_accept, sresp_valid, sresp, sid, serror, sdata, sresp_last
  );
  modport slave (
    input  mcmd_valid, mcmd, mid, maddr, mdata_valid, mdata, mdata_byteen, mdata_last, mresp_accept,
    output scmd_accept, sdata_accept, sresp_valid, sresp, sid, serror, sdata, sresp_last
  );
endinterface

module pzcorebus_outstanding_limiter
  import pzcorebus_pkg::*;
#(
  parameter pzcorebus_config BUS_CONFIG      = '0,
  parameter int              MAX_OUTSTANDING = 8,
  parameter int              COUNT_WIDTH     = $clog2(MAX_OUTSTANDING + 1)
)(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  output logic [COUNT_WIDTH-1:0] o_outstanding,
  output logic                   o_full,
  output logic                   o_error,
  pzcorebus_if.slave             slave_if,
  pzcorebus_if.master            master_if
);
  typedef enum logic {
    OPEN = 1'b0,
    FULL = 1'b1
  } state_e;
  localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = COUNT_WIDTH'(MAX_OUTSTANDING);
  state_e                 r_state;
  state_e                 w_state_next;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic                   w_non_posted;
  logic                   w_block;
  logic                   w_inc;
  logic                   w_dec;
  assign w_non_posted = is_non_posted_command(BUS_CONFIG.profile, slave_if.mcmd);
  // block follows the registered state, so a completion seen in FULL only frees a slot next cycle
  assign w_block      = i_enable && (r_state == FULL) && w_non_posted;
  assign master_if.mcmd_valid   = slave_if.mcmd_valid && !w_block;
  assign slave_if.scmd_accept   = master_if.scmd_accept && !w_block;
  assign master_if.mcmd         = slave_if.mcmd;
  assign master_if.mid          = slave_if.mid;
  assign master_if.maddr        = slave_if.maddr;
  assign master_if.mdata_valid  = slave_if.mdata_valid;
  assign slave_if.sdata_accept  = master_if.sdata_accept;
  assign master_if.mdata        = slave_if.mdata;
  assign master_if.mdata_byteen = slave_if.mdata_byteen;
  assign master_if.mdata_last   = slave_if.mdata_last;
  assign slave_if.sresp_valid   = master_if.sresp_valid;
  assign master_if.mresp_accept = slave_if.mresp_accept;
  assign slave_if.sresp         = master_if.sresp;
  assign slave_if.sid           = master_if.sid;
  assign slave_if.serror        = master_if.serror;
  assign slave_if.sdata         = master_if.sdata;
  assign slave_if.sresp_last    = master_if.sresp_last;
  assign w_inc = master_if.mcmd_valid && master_if.scmd_accept && w_non_posted;
  assign w_dec = master_if.sresp_valid && slave_if.mresp_accept && master_if.sresp_last[0];
  // saturate on increment (reachable only with limiting disabled), clamp at zero on decrement
  always_comb begin
    w_count_next = r_count;
    w_count_next = (w_inc && !w_dec && !(&r_count))     ? r_count + COUNT_WIDTH'(1)
                 : (w_dec && !w_inc && (r_count != '0)) ? r_count - COUNT_WIDTH'(1)
                 : r_count;
  end
  // >= keeps blocking after limiting is re-enabled with the count above the limit
  always_comb begin
    w_state_next = OPEN;
    w_state_next = (w_count_next >= MAX_COUNT) ? FULL : OPEN;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= OPEN;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end
  assign o_outstanding = r_count;
  assign o_full        = (r_state == FULL);
`ifdef PZCOREBUS_OUTSTANDING_LIMITER_ERROR_EN
  logic r_error;
  logic w_underflow;
  assign w_underflow = w_dec && !w_inc && (r_count == '0);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_error <= 1'b0;
    end else if (w_underflow) begin
      r_error <= 1'b1;
    end
  end
  assign o_error = r_error;
`else
  assign o_error = 1'b0;
`endif
endmodule

// File: tb/tb_pzcorebus_outstanding_limiter.sv
// tb_pzcorebus_outstanding_limiter: directed checks of the outstanding limiter with MAX_OUTSTANDING=2
module tb_pzcorebus_outstanding_limiter;
  import pzcorebus_pkg::*;
  localparam pzcorebus_config CFG = '0;
  localparam int MAXO = 2;
  localparam int CW   = 2;
`ifdef PZCOREBUS_OUTSTANDING_LIMITER_ERROR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic [CW-1:0] outstanding;
  logic          full;
  logic          error;
  int            tests = 0;
  int            fails = 0;
  pzcorebus_if #(.BUS_CONFIG(CFG)) s_if();
  pzcorebus_if #(.BUS_CONFIG(CFG)) m_if();
  pzcorebus_outstanding_limiter #(
    .BUS_CONFIG      (CFG),
    .MAX_OUTSTANDING (MAXO),
    .COUNT_WIDTH     (CW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .o_outstanding (outstanding),
    .o_full        (full),
    .o_error       (error),
    .slave_if      (s_if),
    .master_if     (m_if)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic init_bus();
    s_if.mcmd_valid   = 1'b0;
    s_if.mcmd         = PZCOREBUS_NULL_COMMAND;
    s_if.mid          = '0;
    s_if.maddr        = '0;
    s_if.mdata_valid  = 1'b0;
    s_if.mdata        = '0;
    s_if.mdata_byteen = '0;
    s_if.mdata_last   = 1'b0;
    s_if.mresp_accept = 1'b1;
    m_if.scmd_accept  = 1'b1;
    m_if.sdata_accept = 1'b1;
    m_if.sresp_valid  = 1'b0;
    m_if.sresp        = PZCOREBUS_NULL_RESPONSE;
    m_if.sid          = '0;
    m_if.serror       = 1'b0;
    m_if.sdata        = '0;
    m_if.sresp_last   = 2'b00;
  endtask
  task automatic test_reset();
    #1;
    tests++; if (outstanding !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d exp 0", outstanding); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %0b exp 0", full); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %0b exp 0", error); end
    step();
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_limit();
    s_if.mcmd_valid = 1'b1;
    s_if.mcmd       = PZCOREBUS_READ;
    #1;
    tests++; if (s_if.scmd_accept !== 1'b1) begin fails++; $display("FAIL limit_acc1: got %0b exp 1", s_if.scmd_accept); end
    step();
    tests++; if (outstanding !== 2'd1) begin fails++; $display("FAIL limit_cnt1: got %0d exp 1", outstanding); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL limit_full1: got %0b exp 0", full); end
    tests++; if (s_if.scmd_accept !== 1'b1) begin fails++; $display("FAIL limit_acc2: got %0b exp 1", s_if.scmd_accept); end
    step();
    tests++; if (outstanding !== 2'd2) begin fails++; $display("FAIL limit_cnt2: got %0d exp 2", outstanding); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL limit_full2: got %0b exp 1", full); end
    tests++; if (s_if.scmd_accept !== 1'b0) begin fails++; $display("FAIL limit_acc3_held: got %0b exp 0", s_if.scmd_accept); end
    tests++; if (m_if.mcmd_valid !== 1'b0) begin fails++; $display("FAIL limit_valid3_held: got %0b exp 0", m_if.mcmd_valid); end
    step();
    tests++; if (outstanding !== 2'd2) begin fails++; $display("FAIL limit_cnt_hold: got %0d exp 2", outstanding); end
  endtask
  task automatic test_release();
    m_if.sresp_valid = 1'b1;
    m_if.sresp       = PZCOREBUS_RESPONSE_WITH_DATA;
    m_if.sdata       = 32'hA5A5_0001;
    m_if.sresp_last  = 2'b00;
    #1;
    tests++; if (s_if.sresp_valid !== 1'b1) begin fails++; $display("FAIL resp_valid_pass: got %0b exp 1", s_if.sresp_valid); end
    tests++; if (s_if.sdata !== 32'hA5A5_0001) begin fails++; $display("FAIL resp_data_pass: got %h exp a5a50001", s_if.sdata); end
    step();
    tests++; if (outstanding !== 2'd2) begin fails++; $display("FAIL resp_nonlast: got %0d exp 2", outstanding); end
    m_if.sresp_last = 2'b01;
    #1;
    tests++; if (s_if.scmd_accept !== 1'b0) begin fails++; $display("FAIL release_same_cycle: got %0b exp 0", s_if.scmd_accept); end
    step();
    m_if.sresp_valid = 1'b0;
    #1;
    tests++; if (outstanding !== 2'd1) begin fails++; $display("FAIL release_cnt: got %0d exp 1", outstanding); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL release_full: got %0b exp 0", full); end
    tests++; if (s_if.scmd_accept !== 1'b1) begin fails++; $display("FAIL release_acc3: got %0b exp 1", s_if.scmd_accept); end
    step();
    tests++; if (outstanding !== 2'd2) begin fails++; $display("FAIL release_cnt2: got %0d exp 2", outstanding); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL release_full2: got %0b exp 1", full); end
    s_if.mcmd_valid = 1'b0;
  endtask
  task automatic test_simultaneous();
    m_if.sresp_valid = 1'b1;
    m_if.sresp_last  = 2'b01;
    step();
    tests++; if (outstanding !== 2'd1) begin fails++; $display("FAIL simul_pre: got %0d exp 1", outstanding); end
    s_if.mcmd_valid = 1'b1;
    s_if.mcmd       = PZCOREBUS_READ;
    step();
    tests++; if (outstanding !== 2'd1) begin fails++; $display("FAIL simul_cnt: got %0d exp 1", outstanding); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL simul_full: got %0b exp 0", full); end
    s_if.mcmd_valid = 1'b0;
    step();
    m_if.sresp_valid = 1'b0;
    tests++; if (outstanding !== 2'd0) begin fails++; $display("FAIL simul_drain: got %0d exp 0", outstanding); end
  endtask
  task automatic test_posted();
    s_if.mcmd_valid = 1'b1;
    s_if.mcmd       = PZCOREBUS_READ;
    step();
    step();
    s_if.mcmd = PZCOREBUS_WRITE_NON_POSTED;
    #1;
    tests++; if (s_if.scmd_accept !== 1'b0) begin fails++; $display("FAIL np_write_blocked: got %0b exp 0", s_if.scmd_accept); end
    s_if.mcmd         = PZCOREBUS_WRITE;
    s_if.mdata_valid  = 1'b1;
    s_if.mdata_byteen = 4'hF;
    for (int i = 0; i < 4; i++) begin
      s_if.mdata      = 32'hD000_0000 + 32'(i);
      s_if.maddr      = 32'h100 + 32'(i * 4);
      s_if.mdata_last = (i == 3);
      #1;
      tests++; if (s_if.scmd_accept !== 1'b1) begin fails++; $display("FAIL posted_acc%0d: got %0b exp 1", i, s_if.scmd_accept); end
      tests++; if (m_if.mdata !== 32'hD000_0000 + 32'(i)) begin fails++; $display("FAIL posted_data%0d: got %h exp %h", i, m_if.mdata, 32'hD000_0000 + 32'(i)); end
      tests++; if (m_if.maddr !== 32'h100 + 32'(i * 4)) begin fails++; $display("FAIL posted_addr%0d: got %h exp %h", i, m_if.maddr, 32'h100 + 32'(i * 4)); end
      step();
      tests++; if (outstanding !== 2'd2) begin fails++; $display("FAIL posted_cnt%0d: got %0d exp 2", i, outstanding); end
    end
    s_if.mcmd_valid  = 1'b0;
    s_if.mdata_valid = 1'b0;
    m_if.sresp_valid = 1'b1;
    m_if.sresp_last  = 2'b01;
    step();
    step();
    m_if.sresp_valid = 1'b0;
    tests++; if (outstanding !== 2'd0) begin fails++; $display("FAIL posted_drain: got %0d exp 0", outstanding); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL posted_drain_full: got %0b exp 0", full); end
  endtask
  task automatic test_underflow();
    m_if.sresp_valid = 1'b1;
    m_if.sresp_last  = 2'b11;
    step();
    m_if.sresp_valid = 1'b0;
    tests++; if (outstanding !== 2'd0) begin fails++; $display("FAIL underflow_cnt: got %0d exp 0", outstanding); end
    tests++; if (error !== EXP_ERR) begin fails++; $display("FAIL underflow_err: got %0b exp %0b", error, EXP_ERR); end
    step();
    tests++; if (error !== EXP_ERR) begin fails++; $display("FAIL underflow_sticky: got %0b exp %0b", error, EXP_ERR); end
  endtask
  task automatic test_saturate();
    enable          = 1'b0;
    s_if.mcmd_valid = 1'b1;
    s_if.mcmd       = PZCOREBUS_READ;
    step();
    step();
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL disabled_full: got %0b exp 1", full); end
    tests++; if (s_if.scmd_accept !== 1'b1) begin fails++; $display("FAIL disabled_pass: got %0b exp 1", s_if.scmd_accept); end
    step();
    tests++; if (outstanding !== 2'd3) begin fails++; $display("FAIL disabled_cnt3: got %0d exp 3", outstanding); end
    step();
    tests++; if (outstanding !== 2'd3) begin fails++; $display("FAIL disabled_saturate: got %0d exp 3", outstanding); end
    s_if.mcmd_valid = 1'b0;
    enable          = 1'b1;
  endtask
  task automatic test_async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++; if (outstanding !== 2'd0) begin fails++; $display("FAIL areset_cnt: got %0d exp 0", outstanding); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL areset_full: got %0b exp 0", full); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL areset_err: got %0b exp 0", error); end
    #2;
    rst_n = 1'b1;
    step();
    tests++; if (outstanding !== 2'd0) begin fails++; $display("FAIL areset_after: got %0d exp 0", outstanding); end
  endtask
  initial begin
    init_bus();
    test_reset();
    test_limit();
    test_release();
    test_simultaneous();
    test_posted();
    test_underflow();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pzcorebus_outstanding_limiter.md
PZCOREBUS_OUTSTANDING_LIMITER -- requirements
Module: pzcorebus_outstanding_limiter

Placement: directly upstream of the pzcorebus 1-to-m switch slave port. Bounds in-flight non-posted requests so the switch and its targets never see more than MAX_OUTSTANDING.

Interface
REQ-001 Parameter BUS_CONFIG, default '0: pzcorebus_config of both ports.
REQ-002 Parameter MAX_OUTSTANDING, default 8: maximum in-flight non-posted commands; legal range 1..255.
REQ-003 Parameter COUNT_WIDTH, default $clog2(MAX_OUTSTANDING+1): counter width.
REQ-004 Port i_clk  input  1  clock; all state updates on rising edge.
REQ-005 Port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port i_enable  input  1  1 = limiting active; 0 = commands pass regardless of count, counter still tracks.
REQ-007 Port o_outstanding  output  COUNT_WIDTH  current in-flight non-posted count.
REQ-008 Port o_full  output  1  high when state is FULL.
REQ-009 Port o_error  output  1  sticky response-underflow flag (see REQ-024).
REQ-010 Port slave_if  pzcorebus_if.slave  -  upstream request source / response sink.
REQ-011 Port master_if  pzcorebus_if.master  -  downstream port toward the switch.

Function
REQ-012 Command payload, data channel (mdata*) and response payload (sresp*) SHALL pass combinationally, unmodified, with zero latency.
REQ-013 master_if.mcmd_valid SHALL equal slave_if.mcmd_valid AND NOT block; slave_if.scmd_accept SHALL equal master_if.scmd_accept AND NOT block.
REQ-014 block SHALL be high iff i_enable=1, state=FULL, and the presented command is non-posted (is_non_posted_command true); posted commands are never blocked.
REQ-015 Command handshake = master_if.mcmd_valid & master_if.scmd_accept; increment when the handshaken command is non-posted.
REQ-016 Response completion = master_if.sresp_valid & slave_if.mresp_accept & sresp_last[0]; decrement by 1 per completion.
REQ-017 Simultaneous increment and decrement in one cycle SHALL leave the counter unchanged.
REQ-018 State machine: OPEN (count < MAX_OUTSTANDING), FULL (count == MAX_OUTSTANDING); state registered, derived from next count.
REQ-019 OPEN->FULL on the cycle the counter reaches MAX_OUTSTANDING; FULL->OPEN on the cycle after a completion with no simultaneous increment.
REQ-020 A completion in FULL SHALL NOT unblock a command in the same cycle; earliest new non-posted acceptance is the following cycle.
REQ-021 With i_enable=0, counter SHALL saturate at 2**COUNT_WIDTH-1 rather than wrap.
REQ-022 o_outstanding, o_full SHALL be registered outputs.
REQ-023 Response path (sresp_valid, mresp_accept) SHALL never be stalled by this block.
REQ-024 A completion with count == 0 SHALL leave the counter at 0 (no underflow wrap) and, when the feature of REQ-028 is compiled in, set o_error.

Reset
REQ-025 On i_rst_n low: counter = 0, state = OPEN, o_outstanding = 0, o_full = 0, o_error = 0, asynchronously.
REQ-026 Reset asserted mid-transaction SHALL discard all in-flight tracking; upstream and downstream are reset concurrently.
REQ-027 o_error SHALL clear only on reset.

Configuration
REQ-028 Macro PZCOREBUS_OUTSTANDING_LIMITER_ERROR_EN: defined -> o_error flop implemented and set per REQ-024; undefined -> o_error tied to 0, no flop, underflow clamp of REQ-024 still applies.

Verification
REQ-029 MAX_OUTSTANDING=2, i_enable=1, issue 3 back-to-back reads, no responses -> first 2 accepted, o_full=1 after 2nd, 3rd held with scmd_accept=0, o_outstanding=2.
REQ-030 From REQ-029 state, return one read response with sresp_last[0]=1 -> next cycle o_full=0, 3rd read accepted that cycle, o_outstanding returns to 2.
REQ-031 Count=1, same cycle: non-posted command handshake and response completion -> o_outstanding stays 1, state OPEN.
REQ-032 State FULL, present 4 posted writes with data -> all 4 accepted, mdata passes untouched, o_outstanding unchanged.
REQ-033 Count=0, inject a response completion -> o_outstanding=0; o_error=1 with macro defined, 0 without.
REQ-034 Count=3, assert i_rst_n low asynchronously mid-cycle -> o_outstanding=0, o_full=0, o_error=0 immediately, before next clock edge.
